// File: rtl/seven_segment_pkg.sv
// Shared constants for seven-segment capture: active-low a..g patterns, special codes, frame FSM states.
package seven_segment_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;

  // Bit 6 is segment a, bit 0 is segment g; a 0 lights the segment.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'h0;
  localparam logic [DIGIT_W-1:0] ERR_CODE   = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } frame_state_e;

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational inverse of the BCD-to-segment decoder: one active-low pattern to digit/blank/err.
module seven_segment_pattern_decode
  import seven_segment_pkg::*;
(
  input  logic [SEG_W-1:0]   seg_n_i,
  output logic [DIGIT_W-1:0] digit_c_o,
  output logic               blank_c_o,
  output logic               err_c_o
);

  always_comb begin
    digit_c_o = ERR_CODE;
    blank_c_o = 1'b0;
    err_c_o   = 1'b0;
    case (seg_n_i)
      SEG_0:     digit_c_o = 4'd0;
      SEG_1:     digit_c_o = 4'd1;
      SEG_2:     digit_c_o = 4'd2;
      SEG_3:     digit_c_o = 4'd3;
      SEG_4:     digit_c_o = 4'd4;
      SEG_5:     digit_c_o = 4'd5;
      SEG_6:     digit_c_o = 4'd6;
      SEG_7:     digit_c_o = 4'd7;
      SEG_8:     digit_c_o = 4'd8;
      SEG_9:     digit_c_o = 4'd9;
      SEG_BLANK: begin
        digit_c_o = BLANK_CODE;
        blank_c_o = 1'b1;
      end
      default:   err_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Recovers BCD digits from a multiplexed active-low seven-segment bus and
// publishes one frame per complete sweep of all digit positions.
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [1:7]              seg_n_i,
  input  logic [NUM_DIGITS-1:0]   an_n_i,
  input  logic                    out_ready_i,
  output logic                    out_valid_o,
  output logic [4*NUM_DIGITS-1:0] out_digits_o,
  output logic [NUM_DIGITS-1:0]   out_blank_o,
  output logic [NUM_DIGITS-1:0]   out_err_o,
  output logic                    overrun_o
);

  localparam int unsigned DIG_W = DIGIT_W * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0]      seg_q, prev_seg_q;
  logic [NUM_DIGITS-1:0] an_q, prev_an_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  fire_q, fire_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic [NUM_DIGITS-1:0] cap_mask_c;
  logic [DIG_W-1:0]      sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0] sh_err_q, sh_err_d;
  frame_state_e          state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [DIG_W-1:0]      out_digits_q, out_digits_d;
  logic [NUM_DIGITS-1:0] out_blank_q, out_blank_d;
  logic [NUM_DIGITS-1:0] out_err_q, out_err_d;
  logic                  overrun_q, overrun_d;

  logic [DIGIT_W-1:0]    dec_digit_c;
  logic                  dec_blank_c;
  logic                  dec_err_c;

  // prev_* holds the pattern that the counter has been qualifying, so decode it.
  seven_segment_pattern_decode u_decode (
    .seg_n_i   (prev_seg_q),
    .digit_c_o (dec_digit_c),
    .blank_c_o (dec_blank_c),
    .err_c_o   (dec_err_c)
  );

  // Stability counter; fire marks the single cycle the threshold is first reached.
  always_comb begin
    cnt_d = '0;
    if ($onehot(~an_q) && (an_q == prev_an_q) && (seg_q == prev_seg_q)) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    end
    fire_d = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
  end

  // In PUBLISH the seen mask is being cleared, so a capture there starts the next frame.
  always_comb begin
    cap_mask_c = '0;
    if (fire_q) begin
      cap_mask_c = ~prev_an_q & ((state_q == PUBLISH) ? {NUM_DIGITS{1'b1}} : ~seen_q);
    end
  end

  always_comb begin
    sh_digits_d = sh_digits_q;
    sh_blank_d  = sh_blank_q;
    sh_err_d    = sh_err_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (cap_mask_c[i]) begin
        sh_digits_d[DIGIT_W*i +: DIGIT_W] = dec_digit_c;
        sh_blank_d[i]                     = dec_blank_c;
        sh_err_d[i]                       = dec_err_c;
      end
    end
  end

  // Frame FSM and output handshake.
  always_comb begin
    state_d      = state_q;
    seen_d       = seen_q | cap_mask_c;
    out_valid_d  = out_valid_q;
    out_digits_d = out_digits_q;
    out_blank_d  = out_blank_q;
    out_err_d    = out_err_q;
    overrun_d    = 1'b0;
    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      COLLECT: begin
        if (&seen_q) begin
          state_d = PUBLISH;
        end
      end
      PUBLISH: begin
        if (!out_valid_q || out_ready_i) begin
          out_valid_d  = 1'b1;
          out_digits_d = sh_digits_q;
          out_blank_d  = sh_blank_q;
          out_err_d    = sh_err_q;
        end else begin
          overrun_d = 1'b1;
        end
        seen_d  = cap_mask_c;
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      seg_q        <= '0;
      an_q         <= '0;
      prev_seg_q   <= '0;
      prev_an_q    <= '0;
      cnt_q        <= '0;
      fire_q       <= 1'b0;
      seen_q       <= '0;
      sh_digits_q  <= '0;
      sh_blank_q   <= '0;
      sh_err_q     <= '0;
      state_q      <= COLLECT;
      out_valid_q  <= 1'b0;
      out_digits_q <= '0;
      out_blank_q  <= '0;
      out_err_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      seg_q        <= seg_n_i;
      an_q         <= an_n_i;
      prev_seg_q   <= seg_q;
      prev_an_q    <= an_q;
      cnt_q        <= cnt_d;
      fire_q       <= fire_d;
      seen_q       <= seen_d;
      sh_digits_q  <= sh_digits_d;
      sh_blank_q   <= sh_blank_d;
      sh_err_q     <= sh_err_d;
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_digits_q <= out_digits_d;
      out_blank_q  <= out_blank_d;
      out_err_q    <= out_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_digits_o = out_digits_q;
  assign out_blank_o  = out_blank_q;
  assign out_err_o    = out_err_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: directed scenarios plus randomized holds against a frame-level model.
module tb_seven_segment_capture;

  localparam int unsigned N = 4;
  localparam int unsigned S = 16;
  localparam int unsigned W = 6 * N;

  localparam logic [6:0] PATS [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:7]   seg_n;
  logic [N-1:0] an_n;
  logic         out_ready;
  logic         out_valid;
  logic [4*N-1:0] out_digits;
  logic [N-1:0] out_blank;
  logic [N-1:0] out_err;
  logic         overrun;

  int total = 0;
  int bad   = 0;

  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned overruns = 0;
  logic        valid_prev = 1'b0;
  logic [W-1:0] xfers [$];

  seven_segment_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .seg_n_i      (seg_n),
    .an_n_i       (an_n),
    .out_ready_i  (out_ready),
    .out_valid_o  (out_valid),
    .out_digits_o (out_digits),
    .out_blank_o  (out_blank),
    .out_err_o    (out_err),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: accepted frames, overrun pulses and the edge where out_valid rose.
  always @(negedge clk) begin
    if (out_valid && out_ready) xfers.push_back({out_err, out_blank, out_digits});
    if (overrun) overruns++;
    if (out_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = out_valid;
  end

  function automatic logic [5:0] ref_decode(input logic [6:0] seg);
    for (int d = 0; d < 10; d++) begin
      if (seg == PATS[d]) return {2'b00, 4'(d)};
    end
    if (seg == BLANK) return 6'b010000;
    return 6'b101111;
  endfunction

  function automatic logic [W-1:0] frame_word(input logic [6:0] s0, input logic [6:0] s1,
                                              input logic [6:0] s2, input logic [6:0] s3);
    logic [W-1:0] w;
    logic [6:0]   s [N];
    logic [5:0]   d;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    w = '0;
    for (int i = 0; i < N; i++) begin
      d = ref_decode(s[i]);
      w[4*i +: 4] = d[3:0];
      w[4*N + i]  = d[4];
      w[5*N + i]  = d[5];
    end
    return w;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [N-1:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    step(n);
  endtask

  task automatic show(input int pos, input logic [6:0] seg, input int n);
    logic [N-1:0] an;
    an = '1;
    an[pos] = 1'b0;
    hold(an, seg, n);
  endtask

  task automatic idle(input int n);
    hold('1, BLANK, n);
  endtask

  task automatic pulse_reset;
    an_n  = '1;
    seg_n = BLANK;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    out_ready = 1'b1;
    reset = 1'b1;
    an_n  = '1;
    seg_n = BLANK;
    step(2);
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_digits !== '0) begin bad++; $display("FAIL reset_digits got=%h want=0", out_digits); end
    total++; if (out_blank !== '0) begin bad++; $display("FAIL reset_blank got=%b want=0", out_blank); end
    total++; if (out_err !== '0) begin bad++; $display("FAIL reset_err got=%b want=0", out_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
  endtask

  task automatic test_clean_frame;
    int unsigned k;
    int x0;
    out_ready = 1'b1;
    x0 = xfers.size();
    show(0, PATS[1], 20);
    show(1, PATS[2], 20);
    show(2, PATS[3], 20);
    k = cyc;
    show(3, PATS[4], 20);
    idle(10);
    total++; if (xfers.size() != x0 + 1) begin bad++; $display("FAIL clean_count got=%0d want=%0d", xfers.size() - x0, 1); end
    if (xfers.size() > x0) begin
      total++; if (xfers[x0] !== 24'h004321) begin bad++; $display("FAIL clean_frame got=%h want=004321", xfers[x0]); end
    end
    total++; if (rise_cyc != k + S + 4) begin bad++; $display("FAIL clean_latency got=%0d want=%0d", rise_cyc, k + S + 4); end
  endtask

  task automatic test_glitch;
    int x0;
    x0 = xfers.size();
    show(0, PATS[0], S - 1);
    show(0, PATS[9], 20);
    show(1, PATS[1], 20);
    show(2, PATS[2], 20);
    show(3, PATS[3], 20);
    idle(10);
    total++; if (xfers.size() != x0 + 1) begin bad++; $display("FAIL glitch_count got=%0d want=1", xfers.size() - x0); end
    if (xfers.size() > x0) begin
      total++; if (xfers[x0] !== 24'h003219) begin bad++; $display("FAIL glitch_frame got=%h want=003219", xfers[x0]); end
    end
  endtask

  task automatic test_blank_err;
    int x0;
    x0 = xfers.size();
    show(0, PATS[5], 20);
    show(1, PATS[8], 20);
    show(2, BLANK, 20);
    show(3, 7'b1010101, 20);
    idle(10);
    total++; if (xfers.size() != x0 + 1) begin bad++; $display("FAIL blankerr_count got=%0d want=1", xfers.size() - x0); end
    if (xfers.size() > x0) begin
      total++; if (xfers[x0] !== 24'h84F085) begin bad++; $display("FAIL blankerr_frame got=%h want=84f085", xfers[x0]); end
    end
  endtask

  task automatic test_back_to_back;
    int x0;
    int unsigned ov0;
    pulse_reset();
    out_ready = 1'b0;
    x0  = xfers.size();
    ov0 = overruns;
    show(0, PATS[5], 20); show(1, PATS[6], 20); show(2, PATS[7], 20); show(3, PATS[8], 20);
    idle(6);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_validA got=%b want=1", out_valid); end
    total++; if (out_digits !== 16'h8765) begin bad++; $display("FAIL bp_digitsA got=%h want=8765", out_digits); end
    show(0, PATS[0], 20); show(1, PATS[9], 20); show(2, PATS[3], 20); show(3, PATS[2], 20);
    idle(6);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_held got=%b want=1", out_valid); end
    total++; if ({out_err, out_blank, out_digits} !== 24'h008765) begin bad++; $display("FAIL bp_held got=%h want=008765", {out_err, out_blank, out_digits}); end
    total++; if (overruns - ov0 != 1) begin bad++; $display("FAIL bp_overrun got=%0d want=1", overruns - ov0); end
    total++; if (xfers.size() != x0) begin bad++; $display("FAIL bp_no_xfer got=%0d want=0", xfers.size() - x0); end
    out_ready = 1'b1;
    step(1);
    total++; if (xfers.size() != x0 + 1) begin bad++; $display("FAIL bp_accept got=%0d want=1", xfers.size() - x0); end
    if (xfers.size() > x0) begin
      total++; if (xfers[x0] !== 24'h008765) begin bad++; $display("FAIL bp_frame got=%h want=008765", xfers[x0]); end
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b want=0", out_valid); end
  endtask

  task automatic test_illegal_enables;
    int x0;
    pulse_reset();
    out_ready = 1'b1;
    x0 = xfers.size();
    show(2, PATS[7], 20);
    show(3, PATS[1], 20);
    hold(4'b1111, PATS[8], 100);
    hold(4'b1100, PATS[8], 100);
    show(0, PATS[6], 20);
    idle(10);
    total++; if (xfers.size() != x0) begin bad++; $display("FAIL illegal_no_frame got=%0d want=0", xfers.size() - x0); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL illegal_valid got=%b want=0", out_valid); end
    show(1, PATS[2], 20);
    idle(10);
    total++; if (xfers.size() != x0 + 1) begin bad++; $display("FAIL illegal_count got=%0d want=1", xfers.size() - x0); end
    if (xfers.size() > x0) begin
      total++; if (xfers[x0] !== 24'h001726) begin bad++; $display("FAIL illegal_frame got=%h want=001726", xfers[x0]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int x0;
    out_ready = 1'b1;
    x0 = xfers.size();
    show(0, PATS[3], 20); show(1, PATS[3], 20); show(2, PATS[3], 20);
    pulse_reset();
    total++; if (out_digits !== '0) begin bad++; $display("FAIL rst_mid_digits got=%h want=0", out_digits); end
    show(3, PATS[9], 20);
    idle(10);
    total++; if (xfers.size() != x0) begin bad++; $display("FAIL rst_mid_partial got=%0d want=0", xfers.size() - x0); end
    show(0, PATS[4], 20); show(1, PATS[5], 20); show(2, PATS[6], 20);
    idle(10);
    total++; if (xfers.size() != x0 + 1) begin bad++; $display("FAIL rst_mid_count got=%0d want=1", xfers.size() - x0); end
    if (xfers.size() > x0) begin
      total++; if (xfers[x0] !== 24'h009654) begin bad++; $display("FAIL rst_mid_frame got=%h want=009654", xfers[x0]); end
    end
    // Reset while a frame is pending must discard it.
    out_ready = 1'b0;
    x0 = xfers.size();
    show(0, PATS[1], 20); show(1, PATS[1], 20); show(2, PATS[1], 20); show(3, PATS[1], 20);
    idle(6);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pend_valid got=%b want=1", out_valid); end
    pulse_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_pend_clear got=%b want=0", out_valid); end
    out_ready = 1'b1;
    step(5);
    total++; if (xfers.size() != x0) begin bad++; $display("FAIL rst_pend_xfer got=%0d want=0", xfers.size() - x0); end
  endtask

  task automatic test_random;
    logic [N-1:0] an, prev_an, m_seen;
    logic [6:0]   seg, prev_seg;
    logic [6:0]   m_seg [N];
    logic [W-1:0] expq [$];
    int n, pos;
    int unsigned r;
    pulse_reset();
    out_ready = 1'b1;
    xfers.delete();
    m_seen   = '0;
    for (int i = 0; i < N; i++) m_seg[i] = BLANK;
    prev_an  = '1;
    prev_seg = BLANK;
    repeat (150) begin
      do begin
        r = $urandom_range(0, 9);
        an = '1;
        if (r == 1) begin
          an[$urandom_range(0, 1)] = 1'b0;
          an[$urandom_range(2, 3)] = 1'b0;
        end else if (r != 0) begin
          an[$urandom_range(0, N - 1)] = 1'b0;
        end
        r = $urandom_range(0, 9);
        if (r < 7) seg = PATS[$urandom_range(0, 9)];
        else if (r == 7) seg = BLANK;
        else seg = 7'($urandom);
      end while (an == prev_an && seg == prev_seg);
      n = int'($urandom_range(S - 3, S + 8));
      hold(an, seg, n);
      // A legal hold of at least S cycles fills its position once per frame.
      if ($countones(~an) == 1 && n >= S) begin
        pos = 0;
        for (int i = 0; i < N; i++) if (!an[i]) pos = i;
        if (!m_seen[pos]) begin
          m_seen[pos] = 1'b1;
          m_seg[pos]  = seg;
          if (&m_seen) begin
            expq.push_back(frame_word(m_seg[0], m_seg[1], m_seg[2], m_seg[3]));
            m_seen = '0;
          end
        end
      end
      prev_an  = an;
      prev_seg = seg;
    end
    idle(S + 8);
    total++; if (xfers.size() != expq.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", xfers.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < xfers.size(); i++) begin
      total++; if (xfers[i] !== expq[i]) begin bad++; $display("FAIL rand_frame%0d got=%h want=%h", i, xfers[i], expq[i]); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    an_n      = '1;
    seg_n     = BLANK;
    test_reset();
    test_clean_frame();
    test_glitch();
    test_blank_err();
    test_back_to_back();
    test_illegal_enables();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
